// File: rtl/product_result_fifo_taint.sv
// product_result_fifo_taint: captures multiplier products on productDone rising edges into a
// small FIFO with valid/ready output, tracking per-entry data taint and a sticky control taint.
`default_nettype none

module product_result_fifo_taint #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*WIDTH-1:0]           product,
  input  logic                         product_t,
  input  logic                         productDone,
  input  logic                         productDone_t,
  input  logic                         out_ready,
  input  logic                         out_ready_t,
  output logic [2*WIDTH-1:0]           out_data,
  output logic                         out_data_t,
  output logic                         out_valid,
  output logic                         out_valid_t,
  output logic                         full,
  output logic                         full_t,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         overflow_t
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          done_prev;
  logic          occ_t;
  logic          ovf;
  logic          ovf_t;

  logic nonempty;
  logic is_full;
  logic push_req;
  logic pop;
  logic push;
  logic drop;

  assign nonempty = (cnt != '0);
  assign is_full  = (cnt == CW'(DEPTH));
  assign push_req = productDone & ~done_prev;
  assign pop      = nonempty & out_ready;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push     = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      done_prev <= 1'b0;
      occ_t     <= 1'b0;
      ovf       <= 1'b0;
      ovf_t     <= 1'b0;
    end else begin
      done_prev <= productDone;
      occ_t     <= occ_t | productDone_t | (nonempty & out_ready_t);
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf   <= 1'b1;
        ovf_t <= ovf_t | occ_t | productDone_t;
      end
    end
  end

  // Entry storage carries no reset; outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {product_t | productDone_t, product};
  end

  assign out_valid   = nonempty;
  assign out_data    = nonempty ? mem[head][2*WIDTH-1:0] : '0;
  assign out_data_t  = (nonempty & mem[head][2*WIDTH]) | occ_t;
  assign out_valid_t = occ_t;
  assign full        = is_full;
  assign full_t      = occ_t;
  assign count       = cnt;
  assign overflow    = ovf;
  assign overflow_t  = ovf_t;

endmodule

`default_nettype wire

// File: tb/tb_product_result_fifo_taint.sv
// Table-driven bench for product_result_fifo_taint (WIDTH=32, DEPTH=4) plus directed taint/reset sequences.
`default_nettype none

module tb_product_result_fifo_taint;

  logic        clk;
  logic        rst;
  logic [63:0] product;
  logic        product_t;
  logic        productDone;
  logic        productDone_t;
  logic        out_ready;
  logic        out_ready_t;
  logic [63:0] out_data;
  logic        out_data_t;
  logic        out_valid;
  logic        out_valid_t;
  logic        full;
  logic        full_t;
  logic [2:0]  count;
  logic        overflow;
  logic        overflow_t;

  int nvec = 0;
  int nmis = 0;

  product_result_fifo_taint #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .product(product), .product_t(product_t),
    .productDone(productDone), .productDone_t(productDone_t),
    .out_ready(out_ready), .out_ready_t(out_ready_t),
    .out_data(out_data), .out_data_t(out_data_t),
    .out_valid(out_valid), .out_valid_t(out_valid_t),
    .full(full), .full_t(full_t), .count(count),
    .overflow(overflow), .overflow_t(overflow_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    logic        pt, pd, pdt, rdy, rdyt;
    logic        ev;
    logic [63:0] ed;
    logic        edt, et, ef;
    logic [2:0]  ec;
    logic        eo, eot;
  } vec_t;

  function automatic vec_t v(logic [63:0] prod, logic pt, logic pd, logic pdt, logic rdy, logic rdyt,
                             logic ev, logic [63:0] ed, logic edt, logic et, logic ef,
                             logic [2:0] ec, logic eo, logic eot);
    vec_t r;
    r.prod = prod; r.pt = pt; r.pd = pd; r.pdt = pdt; r.rdy = rdy; r.rdyt = rdyt;
    r.ev = ev; r.ed = ed; r.edt = edt; r.et = et; r.ef = ef; r.ec = ec; r.eo = eo; r.eot = eot;
    return r;
  endfunction

  task automatic chk(string nm, logic ev, logic [63:0] ed, logic edt, logic et, logic ef,
                     logic [2:0] ec, logic eo, logic eot);
    nvec++;
    if (out_valid !== ev) begin nmis++; $display("FAIL %s out_valid got %0b want %0b", nm, out_valid, ev); end
    if (out_data !== ed) begin nmis++; $display("FAIL %s out_data got %h want %h", nm, out_data, ed); end
    if (out_data_t !== edt) begin nmis++; $display("FAIL %s out_data_t got %0b want %0b", nm, out_data_t, edt); end
    if (out_valid_t !== et) begin nmis++; $display("FAIL %s out_valid_t got %0b want %0b", nm, out_valid_t, et); end
    if (full_t !== et) begin nmis++; $display("FAIL %s full_t got %0b want %0b", nm, full_t, et); end
    if (full !== ef) begin nmis++; $display("FAIL %s full got %0b want %0b", nm, full, ef); end
    if (count !== ec) begin nmis++; $display("FAIL %s count got %0d want %0d", nm, count, ec); end
    if (overflow !== eo) begin nmis++; $display("FAIL %s overflow got %0b want %0b", nm, overflow, eo); end
    if (overflow_t !== eot) begin nmis++; $display("FAIL %s overflow_t got %0b want %0b", nm, overflow_t, eot); end
  endtask

  task automatic step(logic [63:0] p, logic pt, logic pd, logic pdt, logic rdy, logic rdyt);
    product = p; product_t = pt; productDone = pd; productDone_t = pdt;
    out_ready = rdy; out_ready_t = rdyt;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    product = '0; product_t = 0; productDone = 0; productDone_t = 0; out_ready = 0; out_ready_t = 0;

    // single result, level held 3 cycles, then one pop
    tbl.push_back(v(64'h3F,0,1,0,0,0, 1,64'h3F,0,0,0,1,0,0));
    tbl.push_back(v(64'h3F,0,1,0,0,0, 1,64'h3F,0,0,0,1,0,0));
    tbl.push_back(v(64'h3F,0,1,0,0,0, 1,64'h3F,0,0,0,1,0,0));
    tbl.push_back(v(64'h0 ,0,0,0,1,0, 0,64'h0 ,0,0,0,0,0,0));
    // fill 1..4, then push 9 with simultaneous pop while full
    tbl.push_back(v(64'h1,0,1,0,0,0, 1,64'h1,0,0,0,1,0,0));
    tbl.push_back(v(64'h1,0,0,0,0,0, 1,64'h1,0,0,0,1,0,0));
    tbl.push_back(v(64'h2,0,1,0,0,0, 1,64'h1,0,0,0,2,0,0));
    tbl.push_back(v(64'h2,0,0,0,0,0, 1,64'h1,0,0,0,2,0,0));
    tbl.push_back(v(64'h3,0,1,0,0,0, 1,64'h1,0,0,0,3,0,0));
    tbl.push_back(v(64'h3,0,0,0,0,0, 1,64'h1,0,0,0,3,0,0));
    tbl.push_back(v(64'h4,0,1,0,0,0, 1,64'h1,0,0,1,4,0,0));
    tbl.push_back(v(64'h4,0,0,0,0,0, 1,64'h1,0,0,1,4,0,0));
    tbl.push_back(v(64'h9,0,1,0,1,0, 1,64'h2,0,0,1,4,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h3,0,0,0,3,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h4,0,0,0,2,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h9,0,0,0,1,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 0,64'h0,0,0,0,0,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 0,64'h0,0,0,0,0,0,0));
    // per-entry data taint
    tbl.push_back(v(64'h7,1,1,0,0,0, 1,64'h7,1,0,0,1,0,0));
    tbl.push_back(v(64'h8,0,0,0,0,0, 1,64'h7,1,0,0,1,0,0));
    tbl.push_back(v(64'h8,0,1,0,0,0, 1,64'h7,1,0,0,2,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h8,0,0,0,1,0,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 0,64'h0,0,0,0,0,0,0));
    // fill and overflow
    tbl.push_back(v(64'h1,0,1,0,0,0, 1,64'h1,0,0,0,1,0,0));
    tbl.push_back(v(64'h1,0,0,0,0,0, 1,64'h1,0,0,0,1,0,0));
    tbl.push_back(v(64'h2,0,1,0,0,0, 1,64'h1,0,0,0,2,0,0));
    tbl.push_back(v(64'h2,0,0,0,0,0, 1,64'h1,0,0,0,2,0,0));
    tbl.push_back(v(64'h3,0,1,0,0,0, 1,64'h1,0,0,0,3,0,0));
    tbl.push_back(v(64'h3,0,0,0,0,0, 1,64'h1,0,0,0,3,0,0));
    tbl.push_back(v(64'h4,0,1,0,0,0, 1,64'h1,0,0,1,4,0,0));
    tbl.push_back(v(64'h4,0,0,0,0,0, 1,64'h1,0,0,1,4,0,0));
    tbl.push_back(v(64'h5,0,1,0,0,0, 1,64'h1,0,0,1,4,1,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h2,0,0,0,3,1,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h3,0,0,0,2,1,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 1,64'h4,0,0,0,1,1,0));
    tbl.push_back(v(64'h0,0,0,0,1,0, 0,64'h0,0,0,0,0,1,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 64'h0, 0, 0, 0, 3'd0, 0, 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].prod, tbl[i].pt, tbl[i].pd, tbl[i].pdt, tbl[i].rdy, tbl[i].rdyt);
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].edt, tbl[i].et, tbl[i].ef,
          tbl[i].ec, tbl[i].eo, tbl[i].eot);
    end

    // tainted productDone with no edge sets sticky control taint
    step(64'h0, 0, 0, 1, 0, 0);
    chk("ctl_taint_set", 0, 64'h0, 1, 1, 0, 3'd0, 1, 0);
    step(64'h55, 0, 1, 0, 0, 0);
    chk("ctl_taint_entry", 1, 64'h55, 1, 1, 0, 3'd1, 1, 0);
    step(64'h0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(64'h60 + 64'(k), 0, 1, 0, 0, 0);
      step(64'h0, 0, 0, 0, 0, 0);
    end
    chk("ctl_fill", 1, 64'h55, 1, 1, 1, 3'd4, 1, 0);
    step(64'h77, 0, 1, 0, 0, 0);
    chk("ctl_drop", 1, 64'h55, 1, 1, 1, 3'd4, 1, 1);
    step(64'h0, 0, 0, 0, 1, 0);
    chk("ctl_pop", 1, 64'h61, 1, 1, 0, 3'd3, 1, 1);

    // asynchronous reset between edges
    out_ready = 0;
    #3 rst = 1'b0;
    #1;
    chk("async_reset", 0, 64'h0, 0, 0, 0, 3'd0, 0, 0);

    // done already high when reset releases counts as an edge
    product = 64'hAB; productDone = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("done_at_release", 1, 64'hAB, 0, 0, 0, 3'd1, 0, 0);

    // tainted ready on a real pop sets control taint
    step(64'h0, 0, 0, 0, 1, 1);
    chk("ready_taint", 0, 64'h0, 1, 1, 0, 3'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/product_result_fifo_taint.md
Name: product_result_fifo_taint

Overview:
- Downstream stage of the word-taint-tracked sequential multiplier. It captures each finished product, with its one-bit word taint, when the multiplier's productDone rises.
- Buffers captured results in a small FIFO and presents them to a consumer over a valid/ready handshake.
- Propagates taint conservatively: data taint per entry, plus a sticky control taint covering occupancy and handshake outputs.

Parameters:
- WIDTH, 32, operand width; product and FIFO entries are 2*WIDTH bits.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- product  input  2*WIDTH  multiplier product.
- product_t  input  1  word taint of product.
- productDone  input  1  multiplier done level; may stay high for several cycles.
- productDone_t  input  1  taint of productDone.
- out_ready  input  1  consumer ready.
- out_ready_t  input  1  taint of out_ready.
- out_data  output  2*WIDTH  head entry.
- out_data_t  output  1  taint of out_data.
- out_valid  output  1  FIFO non-empty.
- out_valid_t  output  1  taint of out_valid.
- full  output  1  count equals DEPTH.
- full_t  output  1  taint of full.
- count  output  $clog2(DEPTH+1)  occupancy.
- overflow  output  1  sticky: a result was dropped.
- overflow_t  output  1  taint of overflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - Head/tail pointers, count and done_prev clear to 0; occ_t, overflow and overflow_t clear to 0.
  - All outputs read 0, including out_data and out_data_t. Entry storage need not clear.
  - Reset mid-operation discards all entries immediately.
- Edge detect:
  - push_req = productDone & ~done_prev; done_prev <= productDone every cycle.
  - productDone already high in the first cycle after reset counts as an edge, because done_prev=0.
  - A level held high yields exactly one push.
- Pop: pop = out_valid & out_ready. out_data holds the head entry while out_valid=1. Data is valid in the same cycle as out_valid.
- Push: the entry written is {product, product_t | productDone_t}; tail advances and wraps modulo DEPTH.
- Latency: a push in cycle N gives out_valid=1 and out_data=product in cycle N+1. There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - Non-full: both happen and count is unchanged.
  - Full: the pop frees a slot, the push is accepted, count stays DEPTH and overflow is not set.
- Full, push_req=1, pop=0:
  - The product is dropped, overflow <= 1 and overflow_t <= overflow_t | occ_t | productDone_t.
  - Pointers and count are unchanged.
- Empty, out_ready=1: no pop; pointers are unchanged.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally; count is tracked explicitly; full = (count==DEPTH).
- Control taint:
  - occ_t is sticky, clears only on reset, and updates as occ_t <= occ_t | productDone_t | (out_valid & out_ready_t).
  - Rationale: a tainted push or pop decision makes occupancy and pointer positions secret-dependent.
- Output taint: out_valid_t = occ_t; full_t = occ_t; out_data_t = head entry taint | occ_t.
- No taint bit ever affects data, pointers or handshake values; taint is observation only.

Test Plan:
- Single result, all taints 0:
  - Stimulus: product=0x0000_0000_0000_003F (WIDTH=32) with productDone high for 3 cycles; out_ready=0.
  - Required: exactly one push; cycle after edge out_valid=1, out_data=0x3F, count=1, out_data_t=0; then out_ready=1 for 1 cycle gives count=0 and out_valid=0.
- Fill and overflow, DEPTH=4:
  - Stimulus: 5 done pulses with products 1,2,3,4,5; out_ready=0.
  - Required: full=1 after the 4th; 5th is dropped and overflow=1; draining yields 1,2,3,4 in order, then out_valid=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO holds 1..4; done edge with product=9 in the same cycle as out_ready=1.
  - Required: count stays 4, overflow=0; drain order 2,3,4,9.
- Data taint only:
  - Stimulus: push product=7 with product_t=1, then product=8 with product_t=0.
  - Required: out_data_t=1 while 7 is at head, 0 while 8 is at head; out_valid_t=0 throughout.
- Control taint:
  - Stimulus: productDone_t=1 for one cycle with no edge.
  - Required: from the next cycle out_valid_t=full_t=1, and out_data_t=1 for all later entries until reset; separately, a pop with out_ready_t=1 also sets occ_t.
- Reset mid-operation:
  - Stimulus: FIFO holds 3 entries, overflow=1, occ_t=1; assert rst=0 asynchronously between clock edges.
  - Required: count=0, out_valid=0, overflow=0 and all _t outputs=0 immediately, without waiting for a clock edge.
